bram_burst_reader: RTL

- Read-side initiator for one port of the true dual-port write-first BRAM.
- Accepts a burst command (start address, word count) and issues sequential reads on one BRAM port with 1-cycle read latency.
- Returns the data as a valid/ready stream with last flag and a completion pulse.
- The other BRAM port stays free for a writer; this block never writes.

---
 rtl/bram_burst_reader_pkg.sv | 20 ++
 rtl/rd_buf_fifo.sv | 61 ++++++
 rtl/bram_burst_reader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bram_burst_reader_pkg.sv
// Shared types and sizing for the BRAM burst reader: FSM states, buffer depth
// and the width of the occupancy / in-flight counters.
package bram_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BUF_DEPTH = 3;
  localparam int CNT_W     = 2;

  // Circular pointer step over the BUF_DEPTH buffer slots.
  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == CNT_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/rd_buf_fifo.sv
// Three-entry synchronous FIFO holding read beats (data plus last flag).
// The head entry is presented directly from registers.
module rd_buf_fifo
  import bram_burst_reader_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [CNT_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count_q == CNT_W'(BUF_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Storage is cleared on reset so an idle head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The reader's issue window keeps pushes from ever landing on a full buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_overflow: assert (!(push && full));
    end
  end

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read initiator for one BRAM port: issues sequential 1-cycle-latency
// reads and returns the words as a valid/ready stream with last and done.
module bram_burst_reader
  import bram_burst_reader_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [RAM_ADDR_BITS-1:0] cmd_addr_i,
  input  logic [RAM_ADDR_BITS:0]   cmd_len_i,
  output logic                     bram_en_o,
  output logic                     bram_we_o,
  output logic [RAM_ADDR_BITS-1:0] bram_addr_o,
  output logic [RAM_WIDTH-1:0]     bram_wdata_o,
  input  logic [RAM_WIDTH-1:0]     bram_rdata_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [RAM_WIDTH-1:0]     m_data_o,
  output logic                     m_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output state_t                   state_o
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both
  // high; valid never waits on ready and, once raised, holds until taken.

  state_t                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [RAM_ADDR_BITS:0]   remaining_q;
  logic                     rd_pending_q;
  logic                     rd_last_q;
  logic                     issue;
  logic                     last_issue;
  logic                     cmd_fire;
  logic                     beat_fire;
  logic [CNT_W-1:0]         occ;
  logic [CNT_W:0]           window;
  logic                     buf_full;
  logic                     buf_empty;
  logic [RAM_WIDTH:0]       head;

  assign cmd_fire   = (state_q == IDLE) && cmd_valid_i;
  assign beat_fire  = m_valid_o && m_ready_i;
  assign last_issue = (remaining_q == (RAM_ADDR_BITS + 1)'(1));
  // Registered-only window: m_ready_i never reaches bram_en_o combinationally.
  assign window     = {1'b0, occ} + {{CNT_W{1'b0}}, rd_pending_q};

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) state_d = (cmd_len_i == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        issue = (window < (CNT_W + 1)'(BUF_DEPTH));
        if (issue && last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (beat_fire && m_last_o) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      rd_pending_q <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= issue;
      rd_last_q    <= issue && last_issue;
      if (cmd_fire) begin
        addr_q      <= cmd_addr_i;
        remaining_q <= cmd_len_i;
      end else if (issue) begin
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
    end
  end

  rd_buf_fifo #(
    .WIDTH(RAM_WIDTH + 1)
  ) u_buf (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (rd_pending_q),
    .push_data({rd_last_q, bram_rdata_i}),
    .pop      (beat_fire),
    .pop_data (head),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (occ)
  );

  assign bram_en_o    = issue;
  assign bram_we_o    = 1'b0;
  assign bram_addr_o  = addr_q;
  assign bram_wdata_o = '0;
  assign m_valid_o    = !buf_empty;
  assign m_data_o     = head[RAM_WIDTH-1:0];
  assign m_last_o     = !buf_empty && head[RAM_WIDTH];
  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign state_o      = state_q;

  logic unused_ok;
  assign unused_ok = buf_full;

endmodule
